// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle execute controller producing PC-advance and register-write strobes from decoder controls
//   clock/nreset             : system clock, async active-low reset (synchronised release)
//   instr_valid, regw, ramR,
//   ramW, muldiv, outputbool,
//   writesel                 : decoder controls, held stable until pc_en
//   md_done, adc_ack,
//   dac_busy                 : datapath handshakes
//   pc_en, regw_en           : retire / register write strobes
//   md_start, adc_req,
//   dac_strobe               : datapath requests
//   busy, adc_timeout,
//   stall_cnt                : status
module exec_sequencer #(
  parameter int ADC_TIMEOUT = 255,
  parameter int TO_W        = 8,
  parameter int STALL_W     = 16
) (
  input  logic               clock,
  input  logic               nreset,
  input  logic               instr_valid,
  input  logic               regw,
  input  logic               ramR,
  input  logic               ramW,
  input  logic               muldiv,
  input  logic               outputbool,
  input  logic [2:0]         writesel,
  input  logic               md_done,
  input  logic               adc_ack,
  input  logic               dac_busy,
  output logic               pc_en,
  output logic               regw_en,
  output logic               md_start,
  output logic               adc_req,
  output logic               dac_strobe,
  output logic               busy,
  output logic               adc_timeout,
  output logic [STALL_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {EXEC, LOAD_WAIT, MD_WAIT, ADC_WAIT} state_t;
  state_t          state;
  logic [1:0]      rst_q;
  logic            rstn;
  logic [TO_W-1:0] to_cnt;
  logic            ex, adc_sel, c_md, c_ld, c_adc, c_dac, c_pl;
  logic            in_ld, in_md, in_adc, expire;
  logic            unused_ramw;
  assign unused_ramw = ramW;
  // Reset asserts immediately and releases two clocks after nreset rises.
  always_ff @(posedge clock or negedge nreset)
    if (!nreset) rst_q <= '0;
    else rst_q <= {rst_q[0], 1'b1};
  assign rstn = rst_q[1];
  // Outputs are gated by rstn so a reset mid-instruction kills every strobe at once.
  always_comb begin
    ex       = rstn && state == EXEC && instr_valid;
    adc_sel  = writesel == 3'b100;
    c_md     = ex && muldiv;
    c_ld     = ex && !muldiv && ramR;
    c_adc    = ex && !muldiv && !ramR && adc_sel;
    c_dac    = ex && !muldiv && !ramR && !adc_sel && outputbool;
    c_pl     = ex && !muldiv && !ramR && !adc_sel && !outputbool;
    in_ld    = rstn && state == LOAD_WAIT;
    in_md    = rstn && state == MD_WAIT;
    in_adc   = rstn && state == ADC_WAIT;
    expire   = to_cnt == TO_W'(ADC_TIMEOUT - 1);
    pc_en    = c_pl || (c_dac && !dac_busy) || in_ld || (in_md && md_done) || (in_adc && (adc_ack || expire));
    regw_en  = (c_pl && regw) || in_ld || (in_md && md_done) || (in_adc && adc_ack);
    md_start = c_md;
    adc_req  = in_adc;
    dac_strobe = c_dac && !dac_busy;
    busy     = state != EXEC;
  end
  always_ff @(posedge clock or negedge rstn)
    if (!rstn) begin
      state       <= EXEC;
      to_cnt      <= '0;
      adc_timeout <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      state       <= c_md ? MD_WAIT : c_ld ? LOAD_WAIT : c_adc ? ADC_WAIT : pc_en ? EXEC : state;
      to_cnt      <= in_adc ? to_cnt + TO_W'(1) : '0;
      adc_timeout <= adc_timeout || (in_adc && expire && !adc_ack);
      if (instr_valid && !pc_en && stall_cnt != '1) stall_cnt <= stall_cnt + STALL_W'(1);
    end
endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: directed scoreboard bench for exec_sequencer
module tb_exec_sequencer;
  logic clock = 0, nreset = 0;
  logic instr_valid = 0, regw = 0, ramR = 0, ramW = 0, muldiv = 0, outputbool = 0;
  logic [2:0] writesel = 0;
  logic md_done = 0, adc_ack = 0, dac_busy = 0;
  logic pc_en, regw_en, md_start, adc_req, dac_strobe, busy, adc_timeout;
  logic [3:0] stall_cnt;
  int total = 0, bad = 0;
  int exp_stall = 0;
  logic [5:0] q[$];
  exec_sequencer #(.ADC_TIMEOUT(4), .TO_W(8), .STALL_W(4)) dut (
    .clock(clock), .nreset(nreset), .instr_valid(instr_valid), .regw(regw), .ramR(ramR),
    .ramW(ramW), .muldiv(muldiv), .outputbool(outputbool), .writesel(writesel),
    .md_done(md_done), .adc_ack(adc_ack), .dac_busy(dac_busy), .pc_en(pc_en),
    .regw_en(regw_en), .md_start(md_start), .adc_req(adc_req), .dac_strobe(dac_strobe),
    .busy(busy), .adc_timeout(adc_timeout), .stall_cnt(stall_cnt));
  always #5 clock = ~clock;
  // e = {pc_en, regw_en, md_start, adc_req, dac_strobe, busy}
  task automatic expect_out(input string tag, input logic [5:0] e);
    logic [5:0] got, ex;
    q.push_back(e);
    #1;
    got = {pc_en, regw_en, md_start, adc_req, dac_strobe, busy};
    ex = q.pop_front();
    total++;
    assert (got === ex) else begin
      bad++;
      $error("FAIL %s: got=%b exp=%b", tag, got, ex);
    end
  endtask
  task automatic cyc(input string tag, input logic [5:0] e);
    expect_out(tag, e);
    if (instr_valid && !e[5] && exp_stall != 15) exp_stall++;
    @(negedge clock);
  endtask
  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] ex);
    total++;
    assert (got === ex) else begin
      bad++;
      $error("FAIL %s: got=%0d exp=%0d", tag, got, ex);
    end
  endtask
  task automatic idle();
    {instr_valid, regw, ramR, ramW, muldiv, outputbool, md_done, adc_ack, dac_busy} = '0;
    writesel = 3'b000;
  endtask
  task automatic release_reset();
    idle();
    @(negedge clock);
    nreset = 1;
    repeat (3) @(negedge clock);
    exp_stall = 0;
  endtask
  initial begin
    instr_valid = 1; regw = 1;
    repeat (2) @(negedge clock);
    expect_out("reset_outs", 6'b000000);
    chk("reset_stall", stall_cnt, 0);
    chk("reset_timeout", {3'b0, adc_timeout}, 0);
    release_reset();
    cyc("idle", 6'b000000);
    instr_valid = 1; regw = 1;
    cyc("plain_regw", 6'b110000);
    regw = 0; ramW = 1;
    cyc("plain_store", 6'b100000);
    idle();
    cyc("idle1", 6'b000000);
    chk("plain_stall", stall_cnt, 4'(exp_stall));
    instr_valid = 1; ramR = 1; regw = 1;
    cyc("load_c0", 6'b000000);
    cyc("load_c1", 6'b110001);
    idle();
    cyc("load_after", 6'b000000);
    chk("load_stall", stall_cnt, 1);
    instr_valid = 1; muldiv = 1; ramR = 1; regw = 1; md_done = 1;
    cyc("md_c0", 6'b001000);
    md_done = 0;
    for (int i = 1; i <= 4; i++) cyc("md_wait", 6'b000001);
    md_done = 1;
    cyc("md_done", 6'b110001);
    idle();
    cyc("md_after", 6'b000000);
    chk("md_stall", stall_cnt, 6);
    instr_valid = 1; regw = 1; writesel = 3'b100;
    cyc("adc_ack_c0", 6'b000000);
    for (int i = 1; i <= 3; i++) cyc("adc_ack_wait", 6'b000101);
    adc_ack = 1;
    cyc("adc_ack_c4", 6'b110101);
    idle();
    cyc("adc_ack_after", 6'b000000);
    chk("adc_ack_timeout", {3'b0, adc_timeout}, 0);
    chk("adc_ack_stall", stall_cnt, 10);
    instr_valid = 1; regw = 1; writesel = 3'b100;
    cyc("adc_to_c0", 6'b000000);
    for (int i = 1; i <= 3; i++) cyc("adc_to_wait", 6'b000101);
    cyc("adc_to_c4", 6'b100101);
    idle();
    cyc("adc_to_after", 6'b000000);
    chk("adc_to_timeout", {3'b0, adc_timeout}, 1);
    chk("adc_to_stall", stall_cnt, 14);
    instr_valid = 1; outputbool = 1; dac_busy = 1;
    for (int i = 0; i < 3; i++) cyc("dac_busy", 6'b000000);
    dac_busy = 0;
    cyc("dac_strobe", 6'b100010);
    idle();
    cyc("dac_after", 6'b000000);
    chk("stall_sat", stall_cnt, 4'(exp_stall));
    chk("stall_sat_val", stall_cnt, 15);
    chk("timeout_sticky", {3'b0, adc_timeout}, 1);
    instr_valid = 1; muldiv = 1; regw = 1;
    cyc("rst_md_c0", 6'b001000);
    cyc("rst_md_c1", 6'b000001);
    md_done = 1;
    nreset = 0;
    expect_out("rst_md_outs", 6'b000000);
    release_reset();
    cyc("rst_md_idle", 6'b000000);
    chk("rst_md_stall", stall_cnt, 0);
    chk("rst_md_timeout", {3'b0, adc_timeout}, 0);
    instr_valid = 1; regw = 1; writesel = 3'b100;
    cyc("rst_adc_c0", 6'b000000);
    cyc("rst_adc_c1", 6'b000101);
    nreset = 0;
    expect_out("rst_adc_outs", 6'b000000);
    release_reset();
    cyc("rst_adc_idle", 6'b000000);
    instr_valid = 1; regw = 1;
    cyc("post_rst_plain", 6'b110000);
    idle();
    cyc("post_rst_idle", 6'b000000);
    chk("rst_adc_stall", stall_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
